// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Purpose: shared opcode encodings and flag bit positions for the EXE-stage ALU.
//   ALU_AND/ALU_ADD/ALU_SUB/ALU_OR : 2-bit ALUop encodings
//   FLAG_Z/FLAG_N/FLAG_C/FLAG_V    : bit positions inside the 4-bit Flags_q vector
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// Interface: alu_if
// Purpose: groups the ALU operand, opcode and result/flag signals.
//   A, B, ALUop        : operands and opcode (driven by the stage / master)
//   Output, Zero, Negative, Carry, Overflow : combinational result and flags
//   Result_q, Flags_q  : registered copy, Flags_q = {Zero,Negative,Carry,Overflow}
interface alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       ALUop;
    logic [WIDTH-1:0] Output;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;
    logic [WIDTH-1:0] Result_q;
    logic [3:0]       Flags_q;

    modport master (
        output A, B, ALUop,
        input  Output, Zero, Negative, Carry, Overflow, Result_q, Flags_q
    );

    modport slave (
        input  A, B, ALUop,
        output Output, Zero, Negative, Carry, Overflow, Result_q, Flags_q
    );
endinterface

// File: rtl/alu_addsub.sv
// Module: alu_addsub
// Purpose: WIDTH-bit two's complement adder/subtractor.
//   a_i, b_i   : operands
//   sub_i      : 1 = compute a_i - b_i (invert b, carry-in 1), 0 = a_i + b_i
//   sum_o      : result modulo 2^WIDTH
//   carry_o    : carry out of the MSB (for subtract, 1 means no borrow)
//   overflow_o : signed overflow
module alu_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        full  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    end

    assign sum_o   = full[WIDTH-1:0];
    assign carry_o = full[WIDTH];
    // Same-sign inputs to the adder producing a different-sign sum; with b
    // inverted this reduces to the usual subtract rule.
    assign overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Module: alu
// Purpose: combinational 16-bit AND/ADD/SUB/OR ALU with a registered result/flag copy.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous active-high, clears Result_q and Flags_q only
//   bus   : alu_if slave modport (operands in, combinational and registered results out)
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic   clk,
    input logic   reset,
    alu_if.slave  bus
);
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             is_sub;

    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;

    logic [WIDTH-1:0] result_d, result_q;
    logic [3:0]       flags_d, flags_q;

    assign is_sub = (bus.ALUop == ALU_SUB);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i        (bus.A),
        .b_i        (bus.B),
        .sub_i      (is_sub),
        .sum_o      (as_sum),
        .carry_o    (as_carry),
        .overflow_o (as_ovf)
    );

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (bus.ALUop)
            ALU_AND: result = bus.A & bus.B;
            ALU_ADD, ALU_SUB: begin
                result = as_sum;
                carry  = as_carry;
                ovf    = as_ovf;
            end
            ALU_OR:  result = bus.A | bus.B;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_Z] = (result == '0);
        flags_d[FLAG_N] = result[WIDTH-1];
        flags_d[FLAG_C] = carry;
        flags_d[FLAG_V] = ovf;
        result_d        = result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.Output   = result;
    assign bus.Zero     = flags_d[FLAG_Z];
    assign bus.Negative = flags_d[FLAG_N];
    assign bus.Carry    = flags_d[FLAG_C];
    assign bus.Overflow = flags_d[FLAG_V];
    assign bus.Result_q = result_q;
    assign bus.Flags_q  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vectors with hand-computed expectations pushed into a
// scoreboard queue; a negedge monitor checks combinational outputs and, one cycle
// later, the registered copy.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t reg_q[$];

    alu_if #(.WIDTH(16)) bus ();

    alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drive_vec(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] res, input logic [3:0] flg);
        exp_t e;
        bus.ALUop = op;
        bus.A     = a;
        bus.B     = b;
        e.res     = res;
        e.flg     = flg;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flg);
        @(posedge clk);
        #1;
        drive_vec(op, a, b, res, flg);
    endtask

    // Registered check first, so a vector pushed this negedge is checked next negedge.
    always @(negedge clk) begin
        exp_t e;
        exp_t r;
        if (reg_q.size() > 0) begin
            r = reg_q.pop_front();
            check("result_q", bus.Result_q, r.res);
            check("flags_q", {12'h0, bus.Flags_q}, {12'h0, r.flg});
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("output", bus.Output, e.res);
            check("flags", {12'h0, bus.Zero, bus.Negative, bus.Carry, bus.Overflow},
                  {12'h0, e.flg});
            reg_q.push_back(e);
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.A     = '0;
        bus.B     = '0;
        bus.ALUop = ALU_AND;
        #2;
        check("reset_result_q", bus.Result_q, 16'h0000);
        check("reset_flags_q", {12'h0, bus.Flags_q}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // flags = {Z,N,C,V}
        apply(ALU_AND, 16'h000F, 16'hFFF6, 16'h0006, 4'b0000);
        apply(ALU_ADD, 16'h000F, 16'hFFF6, 16'h0005, 4'b0010);
        apply(ALU_SUB, 16'h000F, 16'hFFF6, 16'h0019, 4'b0000);
        apply(ALU_AND, 16'h000F, 16'h0005, 16'h0005, 4'b0000);
        apply(ALU_ADD, 16'h000F, 16'h0005, 16'h0014, 4'b0000);
        apply(ALU_SUB, 16'h000F, 16'h0005, 16'h000A, 4'b0010);
        apply(ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        apply(ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
        apply(ALU_SUB, 16'h1234, 16'h1234, 16'h0000, 4'b1010);
        apply(ALU_OR,  16'h00F0, 16'h0F0F, 16'h0FFF, 4'b0000);
        apply(ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        apply(ALU_OR,  16'h8000, 16'h0001, 16'h8001, 4'b0100);
        apply(ALU_AND, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000);
        apply(ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100);

        // Let the scoreboard drain so Result_q holds FFFF before reset.
        repeat (3) @(posedge clk);

        #3;
        reset = 1'b1;
        #1;
        check("async_rst_result_q", bus.Result_q, 16'h0000);
        check("async_rst_flags_q", {12'h0, bus.Flags_q}, 16'h0000);
        check("rst_comb_output", bus.Output, 16'hFFFF);
        repeat (2) @(posedge clk);
        #2;
        check("held_rst_result_q", bus.Result_q, 16'h0000);
        check("held_rst_flags_q", {12'h0, bus.Flags_q}, 16'h0000);

        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_vec(ALU_AND, 16'h00FF, 16'h0F0F, 16'h000F, 4'b0000);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0 && reg_q.size() == 0) break;
            @(posedge clk);
        end
        #6;
        if (exp_q.size() != 0 || reg_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size() + reg_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
